// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and helpers for the staged reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {ASSERT, RELEASE, IDLE} seq_state_t;
    typedef enum logic [1:0] {CAUSE_POR, CAUSE_SOFT, CAUSE_WDT} reset_cause_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request handshake and staged reset outputs of the sequencer
interface reset_sequencer_if
    import reset_seq_pkg::*;
#(
    parameter int NumOutputs = 3
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  wdt_kick;
    logic [NumOutputs-1:0] rst_out;
    logic                  done;
    reset_cause_t          cause;

    modport master (
        output req_valid,
        output wdt_kick,
        input  req_ready,
        input  rst_out,
        input  done,
        input  cause
    );

    modport slave (
        input  req_valid,
        input  wdt_kick,
        output req_ready,
        output rst_out,
        output done,
        output cause
    );

endinterface

// File: rtl/reset_seq_timer.sv
// rtl/reset_seq_timer.sv - loadable saturating up-counter with clear and terminal-count flag
module reset_seq_timer #(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_en,
    input  logic [Width-1:0] i_tc_val,
    output logic [Width-1:0] o_count,
    output logic             o_tc
);

    logic [Width-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with hold stretch; optional watchdog under RESET_SEQ_WDT_EN
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NumOutputs = 3,
    parameter int HoldCycles = 16,
    parameter int StepCycles = 4,
    parameter int WdtCycles  = 1024
) (
    input  logic               clk,
    input  logic               reset,
    reset_sequencer_if.slave   bus
);

    localparam int CntW = $clog2(max3(HoldCycles, StepCycles, WdtCycles) + 1);
    localparam int StgW = $clog2(NumOutputs + 1);

    seq_state_t            r_state;
    logic [StgW-1:0]       r_stage;
    logic [NumOutputs-1:0] r_rst_out;
    logic                  r_done;
    logic                  r_ready;
    reset_cause_t          r_cause;

    logic            w_tc;
    logic [CntW-1:0] w_tc_val;
    logic [CntW-1:0] w_unused_step_cnt;
    logic            w_accept;
    logic            w_wdt_fire;

    // One timer covers both the hold phase and each release step.
    assign w_tc_val = (r_state == ASSERT) ? CntW'(HoldCycles - 1) : CntW'(StepCycles - 1);
    assign w_accept = bus.req_valid && r_ready;

    reset_seq_timer #(.Width(CntW)) u_step_timer (
        .clk        (clk),
        .rst        (reset),
        .i_clear    ((r_state == IDLE) || w_tc),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (1'b1),
        .i_tc_val   (w_tc_val),
        .o_count    (w_unused_step_cnt),
        .o_tc       (w_tc)
    );

`ifdef RESET_SEQ_WDT_EN
    logic            w_wdt_tc;
    logic [CntW-1:0] w_unused_wdt_cnt;

    reset_seq_timer #(.Width(CntW)) u_wdt_timer (
        .clk        (clk),
        .rst        (reset),
        .i_clear    ((r_state != IDLE) || bus.wdt_kick),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_state == IDLE),
        .i_tc_val   (CntW'(WdtCycles - 1)),
        .o_count    (w_unused_wdt_cnt),
        .o_tc       (w_wdt_tc)
    );

    assign w_wdt_fire = (r_state == IDLE) && w_wdt_tc && !bus.wdt_kick;
`else
    logic w_unused_kick;
    assign w_unused_kick = bus.wdt_kick;
    assign w_wdt_fire    = 1'b0;
`endif

    // Outputs release by shifting zeros in from bit 0, so index order is implicit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ASSERT;
            r_stage   <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_ready   <= 1'b0;
            r_cause   <= CAUSE_POR;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ASSERT: begin
                    if (w_tc) begin
                        r_rst_out <= r_rst_out << 1;
                        r_stage   <= StgW'(1);
                        if (NumOutputs == 1) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (w_tc) begin
                        r_rst_out <= r_rst_out << 1;
                        if (r_stage == StgW'(NumOutputs - 1)) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (w_accept || w_wdt_fire) begin
                        r_state   <= ASSERT;
                        r_stage   <= '0;
                        r_rst_out <= '1;
                        r_ready   <= 1'b0;
                        r_cause   <= w_accept ? CAUSE_SOFT : CAUSE_WDT;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= ASSERT;
            endcase
        end
    end

    assign bus.rst_out   = r_rst_out;
    assign bus.done      = r_done;
    assign bus.req_ready = r_ready;
    assign bus.cause     = r_cause;

endmodule
